led_seq_player: RTL
===================

Name: led_seq_player

Overview:
- Parametrised LED pattern sequencer: programmable prescaler, loadable pattern memory, address sequencer with four playback modes.
- Successor to the fixed divider + counter + ROM LED chain.
- Adds: runtime pattern load, programmable sequence length, reverse/ping-pong/one-shot modes, pause, single-step and restart.
- Sits at the board top level, driving LED directly from CLK.

Parameters:
- LED_W, 8: LED/pattern word width.
- DEPTH, 32: pattern memory entries (power of two, >= 2); AW = clog2(DEPTH).
- DIV_BY, 25: prescaler period in CLK cycles per automatic step (>= 1).

Ports:
- CLK  in  1  system clock; all logic rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- wr_en  in  1  pattern memory write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  LED_W  write data.
- last_addr  in  AW  final address of the sequence (length = last_addr+1).
- mode  in  2  00 forward-wrap, 01 reverse-wrap, 10 ping-pong, 11 one-shot.
- run  in  1  1 = prescaler runs and auto-advances; 0 = paused.
- step  in  1  one-cycle pulse = advance once (honoured only while run=0).
- restart  in  1  synchronous sequence restart.
- LED  out  LED_W  registered pattern output.
- adr  out  AW  current sequence address.
- done  out  1  one-shot sequence finished.

Behaviour:
- RESET=1 (async) forces:
  - adr=0, prescaler=0, dir=up, done=0, LED=0.
  - Memory contents are not reset (undefined until written).
- Prescaler:
  - Counts 0..DIV_BY-1 while run=1 and holds its value while run=0.
  - tick=1 in the cycle the count equals DIV_BY-1; the count then returns to 0.
  - DIV_BY=1: tick every cycle while run=1.
- Advance condition:
  - adv = (run & tick) | (~run & step).
  - step is ignored while run=1.
- Priority: RESET > restart > adv.
  - restart: adr=0, prescaler=0, dir=up, done=0.
  - In mode 01, restart loads adr=last_addr instead of 0.
- Next address on adv (L = last_addr):
  - 00: adr==L or adr>L -> 0; else adr+1.
  - 01: adr==0 or adr>L -> L; else adr-1.
  - 10, dir up: adr>=L -> dir=down, adr=L-1 (adr=0 if L=0); else adr+1.
  - 10, dir down: adr==0 -> dir=up, adr=1 (adr=0 if L=0); else adr-1.
  - 10, L=0: adr stays 0.
  - 11: adr<L -> adr+1; adr>=L -> adr=L, done=1, no further movement.
  - 11, done=1: adr holds.
- done:
  - Cleared by reset, by restart, or when mode != 11.
  - Set in the same cycle adr reaches L in mode 11 (registered with adr).
- A mode change applies at the next adv. dir is kept; it is relevant only in mode 10.
- Output latency:
  - LED <= mem[adr] every cycle (synchronous read).
  - LED reflects a new adr exactly 1 cycle after adr changes.
- Write port:
  - Synchronous write at CLK when wr_en=1; independent of run/step.
  - Read-during-write to the same address returns old data.
  - The new data appears on LED 2 cycles after the write edge, if adr is unchanged.
- last_addr change mid-run: no immediate jump. Out-of-range adr is corrected at the next adv per the rules above.
- Width rules:
  - All address arithmetic is AW bits, with no wrap beyond the explicit rules.
  - last_addr is compared unsigned.

Test Plan:
- Reset/forward:
  - Stimulus: DIV_BY=4, load mem[i]=i+8'h10, L=3, mode 00, run=1.
  - Required: adr steps every 4 cycles, 0,1,2,3,0.
  - Required: LED 10,11,12,13,10, each 1 cycle after adr.
  - Required: assert RESET mid-count -> adr=0, LED=0 immediately.
- Reverse and ping-pong:
  - Stimulus: L=3, mode 01.
  - Required: adr 3,2,1,0,3.
  - Stimulus: restart, then mode 10.
  - Required: adr 0,1,2,3,2,1,0,1.
  - Stimulus: L=0.
  - Required: adr stays 0.
- One-shot:
  - Stimulus: mode 11, L=2.
  - Required: adr 0,1,2, then done=1 at adr=2; adr holds for 10 further ticks.
  - Stimulus: restart.
  - Required: done=0, adr=0, and the sequence replays.
- Pause/step:
  - Stimulus: run=0 for 20 cycles.
  - Required: adr and prescaler frozen.
  - Stimulus: three step pulses.
  - Required: adr advances by exactly 3.
  - Stimulus: step held with run=1.
  - Required: no extra advances.
- Write hazard:
  - Stimulus: paused at adr=1; write mem[1]=8'hA5.
  - Required: LED shows old value for 1 cycle, then A5 on the 2nd cycle after the write edge.
  - Stimulus: write to another address.
  - Required: LED unchanged.
- Length shrink / prescaler edges:
  - Stimulus: adr=5, set L=2, mode 00.
  - Required: next adv -> adr=0.
  - Stimulus: DIV_BY=1 with run=1.
  - Required: adr advances every cycle.
  - Stimulus: restart coincident with tick.
  - Required: restart wins, adr=0.

Source files
------------

// File: rtl/led_seq_player.sv
// LED pattern sequencer: a prescaled auto-advance or a single step walks a loadable
// pattern memory in forward, reverse, ping-pong or one-shot order.
//
// dir      | meaning
// DIR_UP   | ping-pong is walking toward last_addr
// DIR_DOWN | ping-pong is walking toward 0
module led_seq_player #(
  parameter int LED_W  = 8,
  parameter int DEPTH  = 32,
  parameter int DIV_BY = 25,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [LED_W-1:0] wr_data,
  input  logic [AW-1:0]    last_addr,
  input  logic [1:0]       mode,
  input  logic             run,
  input  logic             step,
  input  logic             restart,
  output logic [LED_W-1:0] LED,
  output logic [AW-1:0]    adr,
  output logic             done
);

  localparam int PW = (DIV_BY > 1) ? $clog2(DIV_BY) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV_BY - 1);

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [LED_W-1:0] mem [DEPTH];
  logic [PW-1:0]    presc;
  logic             tick;
  logic             adv;
  dir_t             dir;
  dir_t             dir_nxt;
  logic [AW-1:0]    adr_nxt;
  logic             done_nxt;

  assign tick = (presc == PRESC_MAX);
  assign adv  = run ? tick : step;

  // Out-of-range adr (after last_addr shrinks) is folded back by these rules.
  always_comb begin
    adr_nxt  = adr;
    dir_nxt  = dir;
    done_nxt = done;
    case (mode)
      2'b00: adr_nxt = (adr >= last_addr) ? '0 : adr + AW'(1);
      2'b01: adr_nxt = (adr == '0 || adr > last_addr) ? last_addr : adr - AW'(1);
      2'b10: begin
        if (dir == DIR_UP) begin
          if (adr >= last_addr) begin
            dir_nxt = DIR_DOWN;
            adr_nxt = (last_addr == '0) ? '0 : last_addr - AW'(1);
          end else begin
            adr_nxt = adr + AW'(1);
          end
        end else begin
          if (adr == '0) begin
            dir_nxt = DIR_UP;
            adr_nxt = (last_addr == '0) ? '0 : AW'(1);
          end else begin
            adr_nxt = adr - AW'(1);
          end
        end
      end
      default: begin
        if (!done) begin
          if (adr < last_addr) begin
            adr_nxt  = adr + AW'(1);
            done_nxt = (adr + AW'(1) == last_addr);
          end else begin
            adr_nxt  = last_addr;
            done_nxt = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      presc <= '0;
      adr   <= '0;
      dir   <= DIR_UP;
      done  <= 1'b0;
    end else if (restart) begin
      presc <= '0;
      adr   <= (mode == 2'b01) ? last_addr : '0;
      dir   <= DIR_UP;
      done  <= 1'b0;
    end else begin
      if (run) presc <= tick ? '0 : presc + PW'(1);
      if (adv) begin
        adr <= adr_nxt;
        dir <= dir_nxt;
      end
      done <= (mode == 2'b11) && (adv ? done_nxt : done);
    end
  end

  // Pattern storage is deliberately left unreset; a same-address read returns old data.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) LED <= '0;
    else       LED <= mem[adr];
  end

endmodule
